// File: rtl/led_panel_pkg.sv
// Shared geometry, state encoding and write-payload types for the LED panel
// memory write path.
//   DISPLAY_ROWS_LINES / DISPLAY_COLS_LINES : log2 rows per half panel / columns
//   AW : memory address width (MSB selects upper/lower half)
//   DW : pixel width (8 bits each of R, G, B)
package led_panel_pkg;

    localparam int unsigned DISPLAY_ROWS_LINES = 4;
    localparam int unsigned DISPLAY_COLS_LINES = 6;
    localparam int unsigned AW = DISPLAY_ROWS_LINES + DISPLAY_COLS_LINES + 1;
    localparam int unsigned DW = 24;

    // Scheduler FSM: arbitrating between writers, or fill engine owns the port
    typedef enum logic {
        ARB  = 1'b0,
        FILL = 1'b1
    } state_e;

    // Requester identity, used for round-robin fairness
    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

    // One memory write word
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } mem_wr_t;

endpackage

// File: rtl/led_vsync_edge.sv
// Brings the asynchronous panel v_sync into the clock200 domain and flags its
// rising edge with a single-cycle registered pulse.
//   clock200_i   : system clock
//   reset_i      : synchronous active-high reset
//   v_sync_i     : raw panel vertical sync (asynchronous)
//   vsync_rise_o : one-cycle pulse per synchronized rising edge
module led_vsync_edge (
    input  logic clock200_i,
    input  logic reset_i,
    input  logic v_sync_i,
    output logic vsync_rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic rise_q;

    // Two-flop synchronizer, then edge detect on the settled copy only
    always_ff @(posedge clock200_i) begin
        if (reset_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= v_sync_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            rise_q  <= sync2_q & ~prev_q;
        end
    end

    assign vsync_rise_o = rise_q;

endmodule

// File: rtl/led_mem_write_scheduler.sv
// Shares the panel frame-memory write port between writer A (CPU bridge) and
// writer B (stream source) with round-robin arbitration, runs a whole-memory
// colour fill that pre-empts both, and releases back-buffer flips only on a
// v_sync rising edge while no fill is running.
//   a_*/b_*       : writer request/address/data in, combinational grant out
//   fill_*        : fill start/colour in, busy/done out
//   flip_req/v_sync in, flip_pending/flip_pulse out
//   mem_addr/mem_data/mem_write : registered memory write port
module led_mem_write_scheduler
    import led_panel_pkg::*;
(
    input  logic          clock200,
    input  logic          reset,
    input  logic          a_req,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    output logic          a_grant,
    input  logic          b_req,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_data,
    output logic          b_grant,
    input  logic          fill_start,
    input  logic [DW-1:0] fill_color,
    output logic          fill_busy,
    output logic          fill_done,
    input  logic          flip_req,
    input  logic          v_sync,
    output logic          flip_pending,
    output logic          flip_pulse,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    output logic          mem_write
);

    state_e        state_q, state_d;
    req_id_e       last_q, last_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] color_q, color_d;
    mem_wr_t       wr_q, wr_d;
    logic          write_q, write_d;
    logic          done_q, done_d;
    logic          pend_q, pend_d;
    logic          pulse_q, pulse_d;
    logic          vsync_rise;

    led_vsync_edge u_vsync_edge (
        .clock200_i   (clock200),
        .reset_i      (reset),
        .v_sync_i     (v_sync),
        .vsync_rise_o (vsync_rise)
    );

    // Arbitration, fill sequencing and next write word
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        color_d = color_q;
        wr_d    = wr_q;
        write_d = 1'b0;
        done_d  = 1'b0;
        a_grant = 1'b0;
        b_grant = 1'b0;

        case (state_q)
            ARB: begin
                // Under contention, the writer not served last wins
                if (a_req && (!b_req || last_q == REQ_B)) begin
                    a_grant = 1'b1;
                end else if (b_req) begin
                    b_grant = 1'b1;
                end

                if (a_grant) begin
                    write_d   = 1'b1;
                    wr_d.addr = a_addr;
                    wr_d.data = a_data;
                    last_d    = REQ_A;
                end else if (b_grant) begin
                    write_d   = 1'b1;
                    wr_d.addr = b_addr;
                    wr_d.data = b_data;
                    last_d    = REQ_B;
                end

                // A grant issued alongside fill_start still completes
                if (fill_start) begin
                    state_d = FILL;
                    color_d = fill_color;
                    cnt_d   = '0;
                end
            end
            FILL: begin
                write_d   = 1'b1;
                wr_d.addr = cnt_q;
                wr_d.data = color_q;
                cnt_d     = cnt_q + AW'(1);
                if (cnt_q == {AW{1'b1}}) begin
                    done_d  = 1'b1;
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    // Flip release: a rising edge during a fill leaves the request pending
    always_comb begin
        pend_d  = pend_q | flip_req;
        pulse_d = 1'b0;
        if (vsync_rise && state_q == ARB && (pend_q || flip_req)) begin
            pulse_d = 1'b1;
            pend_d  = 1'b0;
        end
    end

    always_ff @(posedge clock200) begin
        if (reset) begin
            state_q <= ARB;
            last_q  <= REQ_B;
            cnt_q   <= '0;
            color_q <= '0;
            wr_q    <= '0;
            write_q <= 1'b0;
            done_q  <= 1'b0;
            pend_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            color_q <= color_d;
            wr_q    <= wr_d;
            write_q <= write_d;
            done_q  <= done_d;
            pend_q  <= pend_d;
            pulse_q <= pulse_d;
        end
    end

    assign mem_addr     = wr_q.addr;
    assign mem_data     = wr_q.data;
    assign mem_write    = write_q;
    assign fill_busy    = (state_q == FILL);
    assign fill_done    = done_q;
    assign flip_pending = pend_q;
    assign flip_pulse   = pulse_q;

endmodule

// File: tb/tb_led_mem_write_scheduler.sv
// Bench for led_mem_write_scheduler: directed scenarios with literal
// expectations plus randomized traffic against a cycle-level behavioural model.
module tb_led_mem_write_scheduler;
    import led_panel_pkg::*;

    localparam int unsigned NW = 1 << AW;

    logic          clock200 = 1'b0;
    logic          reset;
    logic          a_req, b_req, fill_start, flip_req, v_sync;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_data, b_data, fill_color;
    logic          a_grant, b_grant, fill_busy, fill_done;
    logic          flip_pending, flip_pulse, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;

    always #5 clock200 = ~clock200;

    led_mem_write_scheduler dut (
        .clock200     (clock200),
        .reset        (reset),
        .a_req        (a_req),
        .a_addr       (a_addr),
        .a_data       (a_data),
        .a_grant      (a_grant),
        .b_req        (b_req),
        .b_addr       (b_addr),
        .b_data       (b_data),
        .b_grant      (b_grant),
        .fill_start   (fill_start),
        .fill_color   (fill_color),
        .fill_busy    (fill_busy),
        .fill_done    (fill_done),
        .flip_req     (flip_req),
        .v_sync       (v_sync),
        .flip_pending (flip_pending),
        .flip_pulse   (flip_pulse),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_write    (mem_write)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what the outputs must be in the current cycle
    bit            chk_en = 1'b0;
    bit            m_fill, m_last, m_pend, m_pulse, m_done, m_wr;
    int unsigned   m_cnt;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data, m_color;
    logic [3:0]    vh;        // vh[i] = v_sync seen at the edge i+1 cycles ago
    bit            ga, gb, rise, was_fill;

    initial begin
        m_fill = 0; m_last = 1; m_pend = 0; m_pulse = 0; m_done = 0; m_wr = 0;
        m_cnt = 0; m_addr = '0; m_data = '0; m_color = '0; vh = '0;
        forever begin
            @(negedge clock200);
            ga = !m_fill && a_req && (!b_req || m_last);
            gb = !m_fill && b_req && !ga;
            if (chk_en) begin
                chk("a_grant", 32'(a_grant), 32'(ga));
                chk("b_grant", 32'(b_grant), 32'(gb));
                chk("mem_write", 32'(mem_write), 32'(m_wr));
                if (m_wr) begin
                    chk("mem_addr", 32'(mem_addr), 32'(m_addr));
                    chk("mem_data", 32'(mem_data), 32'(m_data));
                end
                chk("fill_busy", 32'(fill_busy), 32'(m_fill));
                chk("fill_done", 32'(fill_done), 32'(m_done));
                chk("flip_pending", 32'(flip_pending), 32'(m_pend));
                chk("flip_pulse", 32'(flip_pulse), 32'(m_pulse));
            end
            // Inputs now present are those sampled at the coming edge
            if (reset) begin
                m_fill = 0; m_last = 1; m_pend = 0; m_pulse = 0; m_done = 0; m_wr = 0;
                m_cnt = 0; m_addr = '0; m_data = '0; vh = '0;
                chk_en = 1'b1;
            end else begin
                was_fill = m_fill;
                m_wr = 0;
                m_done = 0;
                if (m_fill) begin
                    m_wr = 1; m_addr = AW'(m_cnt); m_data = m_color;
                    if (m_cnt == NW - 1) begin m_done = 1; m_fill = 0; end
                    m_cnt++;
                end else begin
                    if (ga) begin m_wr = 1; m_addr = a_addr; m_data = a_data; m_last = 0; end
                    else if (gb) begin m_wr = 1; m_addr = b_addr; m_data = b_data; m_last = 1; end
                    if (fill_start) begin m_fill = 1; m_cnt = 0; m_color = fill_color; end
                end
                // Edge becomes usable three edges after v_sync is first sampled high
                rise = vh[2] && !vh[3];
                if (rise && !was_fill && (m_pend || flip_req)) begin
                    m_pulse = 1; m_pend = 0;
                end else begin
                    m_pulse = 0; m_pend = m_pend || flip_req;
                end
                vh = {vh[2:0], v_sync};
            end
        end
    end

    task automatic cyc();
        @(posedge clock200);
        #1;
    endtask

    task automatic do_reset();
        cyc(); reset = 1'b1;
        cyc(); cyc(); reset = 1'b0;
    endtask

    int  n_busy, n_wr, n_done, n_pulse, n_gnt;
    logic [AW-1:0] done_addr;
    bit  fin;

    initial begin
        reset = 1'b1; a_req = 0; b_req = 0; fill_start = 0; flip_req = 0; v_sync = 0;
        a_addr = '0; b_addr = '0; a_data = '0; b_data = '0; fill_color = '0;
        repeat (3) cyc();
        reset = 1'b0;

        // Reset state
        @(negedge clock200);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_data", 32'(mem_data), 32'd0);
        chk("rst_fill_busy", 32'(fill_busy), 32'd0);
        chk("rst_flip_pending", 32'(flip_pending), 32'd0);

        // Single writer
        cyc(); a_req = 1; a_addr = AW'(11'h005); a_data = DW'(24'hFF0000);
        @(negedge clock200);
        chk("single_grant", 32'(a_grant), 32'd1);
        cyc(); a_req = 0;
        @(negedge clock200);
        chk("single_write", 32'(mem_write), 32'd1);
        chk("single_addr", 32'(mem_addr), 32'h005);
        chk("single_data", 32'(mem_data), 32'hFF0000);

        // Contention right after reset: A, B, A, B
        do_reset();
        a_req = 1; b_req = 1;
        a_addr = AW'(11'h0A1); a_data = DW'(24'h0000AA);
        b_addr = AW'(11'h0B2); b_data = DW'(24'h0000BB);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock200);
            chk("cont_a_grant", 32'(a_grant), 32'(i % 2 == 0));
            chk("cont_b_grant", 32'(b_grant), 32'(i % 2 == 1));
            if (i > 0) chk("cont_addr", 32'(mem_addr), (i % 2 == 1) ? 32'h0A1 : 32'h0B2);
            cyc();
        end
        a_req = 0; b_req = 0;
        @(negedge clock200);
        chk("cont_last_write", 32'(mem_write), 32'd1);
        chk("cont_last_addr", 32'(mem_addr), 32'h0B2);

        // Fill with a pending flip and a v_sync rise during the fill
        cyc(); flip_req = 1;
        cyc(); flip_req = 0; fill_start = 1; fill_color = DW'(24'h00FF00);
        a_req = 1; a_addr = AW'(11'h010); a_data = DW'(24'h123456);
        cyc(); fill_start = 0;
        n_busy = 0; n_wr = 0; n_done = 0; n_pulse = 0; n_gnt = 0; done_addr = '0; fin = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock200);
            if (mem_write && mem_data == DW'(24'h00FF00)) n_wr++;
            if (fill_done) begin n_done++; done_addr = mem_addr; end
            if (fill_busy) begin
                n_busy++;
                if (flip_pulse) n_pulse++;
                if (a_grant || b_grant) n_gnt++;
            end else begin
                fin = 1;
                break;
            end
            cyc();
            if (i == 100) v_sync = 1;
            if (i == 150) v_sync = 0;
        end
        chk("fill_finished", 32'(fin), 32'd1);
        chk("fill_busy_cycles", 32'(n_busy), 32'd2048);
        chk("fill_writes", 32'(n_wr), 32'd2048);
        chk("fill_done_count", 32'(n_done), 32'd1);
        chk("fill_done_addr", 32'(done_addr), 32'h7FF);
        chk("fill_no_pulse", 32'(n_pulse), 32'd0);
        chk("fill_no_grant", 32'(n_gnt), 32'd0);
        chk("fill_resume_grant", 32'(a_grant), 32'd1);
        chk("fill_flip_deferred", 32'(flip_pending), 32'd1);
        cyc(); a_req = 0; v_sync = 1;
        n_pulse = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock200);
            if (flip_pulse) n_pulse++;
            cyc();
        end
        chk("deferred_pulse_count", 32'(n_pulse), 32'd1);
        chk("deferred_pending_clear", 32'(flip_pending), 32'd0);
        v_sync = 0;
        repeat (6) cyc();

        // flip_req in the very cycle the synchronized edge is detected
        v_sync = 1;
        repeat (3) @(posedge clock200);
        #1 flip_req = 1;
        cyc(); flip_req = 0;
        @(negedge clock200);
        chk("simul_pulse", 32'(flip_pulse), 32'd1);
        chk("simul_pending", 32'(flip_pending), 32'd0);
        cyc();
        @(negedge clock200);
        chk("simul_pending_after", 32'(flip_pending), 32'd0);
        cyc(); v_sync = 0;
        repeat (5) cyc();
        v_sync = 1;
        n_pulse = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock200);
            if (flip_pulse) n_pulse++;
            cyc();
        end
        chk("second_edge_no_pulse", 32'(n_pulse), 32'd0);
        v_sync = 0;

        // Reset in the middle of a fill
        cyc(); flip_req = 1;
        cyc(); flip_req = 0; fill_start = 1; fill_color = DW'($urandom);
        cyc(); fill_start = 0;
        n_wr = 0; n_done = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock200);
            if (mem_write) n_wr++;
            if (fill_done) n_done++;
            if (n_wr == 99) break;
            cyc();
        end
        cyc(); reset = 1;
        cyc(); reset = 0; a_req = 1; a_addr = AW'($urandom); a_data = DW'($urandom);
        @(negedge clock200);
        chk("midrst_mem_write", 32'(mem_write), 32'd0);
        chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
        chk("midrst_mem_data", 32'(mem_data), 32'd0);
        chk("midrst_fill_busy", 32'(fill_busy), 32'd0);
        chk("midrst_fill_done", 32'(fill_done), 32'd0);
        chk("midrst_pending", 32'(flip_pending), 32'd0);
        chk("midrst_no_done", 32'(n_done), 32'd0);
        chk("midrst_grant", 32'(a_grant), 32'd1);
        cyc(); a_req = 0;

        // Randomized traffic checked by the model every cycle
        for (int i = 0; i < 4000; i++) begin
            cyc();
            reset      = ($urandom % 1500) == 0;
            a_req      = ($urandom % 3) != 0;
            b_req      = ($urandom % 3) != 0;
            a_addr     = AW'($urandom);
            b_addr     = AW'($urandom);
            a_data     = DW'($urandom);
            b_data     = DW'($urandom);
            fill_start = ($urandom % 600) == 0;
            fill_color = DW'($urandom);
            flip_req   = ($urandom % 40) == 0;
            if (($urandom % 15) == 0) v_sync = ~v_sync;
        end
        cyc();
        reset = 0; a_req = 0; b_req = 0; fill_start = 0; flip_req = 0;
        repeat (3) cyc();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
